// File: rtl/vp_result_packer_if.sv
// rtl/vp_result_packer_if.sv - byte-in / word-out handshake bundle for vp_result_packer
// drop_count is present only when VP_PACK_DROP_CNT_EN is defined.
interface vp_result_packer_if #(
  parameter int LVL_W = 3
);
  logic [7:0]       f;
  logic             f_valid;
  logic             flush;
  logic [31:0]      out_data;
  logic [2:0]       out_bytes;
  logic             out_valid;
  logic             out_ready;
  logic [LVL_W-1:0] level;
  logic             overflow;
  logic             clear_ovf;
`ifdef VP_PACK_DROP_CNT_EN
  logic [7:0]       drop_count;

  modport slave (
    input  f, f_valid, flush, out_ready, clear_ovf,
    output out_data, out_bytes, out_valid, level, overflow, drop_count
  );
  modport master (
    output f, f_valid, flush, out_ready, clear_ovf,
    input  out_data, out_bytes, out_valid, level, overflow, drop_count
  );
`else
  modport slave (
    input  f, f_valid, flush, out_ready, clear_ovf,
    output out_data, out_bytes, out_valid, level, overflow
  );
  modport master (
    output f, f_valid, flush, out_ready, clear_ovf,
    input  out_data, out_bytes, out_valid, level, overflow
  );
`endif
endinterface

// File: rtl/vp_result_packer.sv
// rtl/vp_result_packer.sv - packs the 8-bit result stream into 32-bit words behind a small FIFO
// Optional VP_PACK_DROP_CNT_EN adds a saturating dropped-word counter.
module vp_result_packer #(
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = 3
) (
  input  logic              clk,
  input  logic              reset,
  vp_result_packer_if.slave bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [1:0]       r_lane;
  logic [7:0]       r_b0;
  logic [7:0]       r_b1;
  logic [7:0]       r_b2;
  logic [31:0]      r_mem_data  [FIFO_DEPTH];
  logic [2:0]       r_mem_bytes [FIFO_DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [LVL_W-1:0] r_level;
  logic             r_out_valid;
  logic             r_overflow;

  logic [31:0]      w_raw;
  logic [31:0]      w_word;
  logic [2:0]       w_cnt;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_accept;
  logic             w_drop;
  logic [LVL_W-1:0] w_level_nxt;

  // The incoming byte is merged into its lane first so flush+f_valid pushes lane+1 bytes.
  always_comb begin
    w_raw = {8'h00, r_b2, r_b1, r_b0};
    if (bus.f_valid) begin
      w_raw[{r_lane, 3'b000} +: 8] = bus.f;
    end
    w_cnt  = {1'b0, r_lane} + {2'b00, bus.f_valid};
    w_push = (w_cnt == 3'd4) || (bus.flush && (w_cnt != 3'd0));
    w_word = '0;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < w_cnt) begin
        w_word[i*8 +: 8] = w_raw[i*8 +: 8];
      end
    end
  end

  always_comb begin
    w_full      = (r_level == LVL_W'(FIFO_DEPTH));
    w_pop       = r_out_valid && bus.out_ready;
    w_accept    = w_push && (!w_full || w_pop);
    w_drop      = w_push && !w_accept;
    w_level_nxt = r_level + LVL_W'(w_accept) - LVL_W'(w_pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lane <= 2'd0;
      r_b0   <= 8'h00;
      r_b1   <= 8'h00;
      r_b2   <= 8'h00;
    end else if (w_push) begin
      r_lane <= 2'd0;
    end else if (bus.f_valid) begin
      r_lane <= r_lane + 2'd1;
      case (r_lane)
        2'd0:    r_b0 <= bus.f;
        2'd1:    r_b1 <= bus.f;
        default: r_b2 <= bus.f;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_data[i]  <= '0;
        r_mem_bytes[i] <= '0;
      end
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_level     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mem_data[r_wr_ptr]  <= w_word;
        r_mem_bytes[r_wr_ptr] <= w_cnt;
        r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_level     <= w_level_nxt;
      r_out_valid <= (w_level_nxt != '0);
    end
  end

  // A drop in the same cycle as clear_ovf keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (bus.clear_ovf) begin
      r_overflow <= 1'b0;
    end
  end

`ifdef VP_PACK_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_drop_cnt <= 8'd0;
    end else if (w_drop && bus.clear_ovf) begin
      r_drop_cnt <= 8'd1;
    end else if (w_drop) begin
      if (r_drop_cnt != 8'hff) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end else if (bus.clear_ovf) begin
      r_drop_cnt <= 8'd0;
    end
  end

  assign bus.drop_count = r_drop_cnt;
`endif

  assign bus.out_data  = r_mem_data[r_rd_ptr];
  assign bus.out_bytes = r_mem_bytes[r_rd_ptr];
  assign bus.out_valid = r_out_valid;
  assign bus.level     = r_level;
  assign bus.overflow  = r_overflow;

endmodule

// File: doc/vp_result_packer.md
# vp_result_packer

Downstream stage of the vector processor core: consumes the 8-bit result stream `f` one byte per clock and packs consecutive bytes into 32-bit words. Packed words go into a small FIFO and are offered to the host/memory side over a valid/ready handshake. A partial final word can be flushed. Dropped words are flagged with a sticky overflow flag.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: word FIFO entries; power of two, 2..16.
- `LVL_W`, default 3: width of `level`; equals log2(FIFO_DEPTH)+1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `f`  in  8  result byte from the core.
- `f_valid`  in  1  `f` holds a valid byte this cycle.
- `flush`  in  1  push the partially packed word now.
- `out_data`  out  32  head word; first-received byte in [7:0], then [15:8], [23:16], [31:24].
- `out_bytes`  out  3  number of valid bytes in `out_data`, 1..4.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts the head word.
- `level`  out  LVL_W  FIFO occupancy, 0..FIFO_DEPTH.
- `overflow`  out  1  sticky; a word was dropped.
- `clear_ovf`  in  1  clears `overflow` and, when configured, `drop_count`.

## Operation
- Packer state: lane counter 0..3 and three byte registers b0..b2.
- `f_valid` with lane<3: store `f` in b[lane]; lane+1.
- `f_valid` with lane==3: form word {f,b2,b1,b0} with byte count 4; push; lane returns to 0.
- `flush` with lane>0 and no `f_valid`: form a word from b0..b[lane-1]; unused upper bytes are 0; byte count = lane; push; lane returns to 0.
- `flush` together with `f_valid`: the byte is packed first, then the flush applies.
  - The result is lane+1 bytes; a full 4-byte word when lane was 3.
  - Only one word is pushed per cycle.
- `flush` with lane==0 and no `f_valid`: no effect.
- FIFO: registered storage with read pointer and write pointer, each FIFO_DEPTH-wrapping.
  - Pointers wrap from FIFO_DEPTH-1 to 0.
  - `out_data`/`out_bytes` show the entry at the read pointer.
- Pop: occurs when `out_valid` && `out_ready`.
- Push accepted: when level<FIFO_DEPTH, or when level==FIFO_DEPTH and a pop occurs in the same cycle.
- Push on a full FIFO with no pop:
  - the word is dropped;
  - `overflow` is set to 1;
  - the lane still returns to 0, so packing continues on a fresh word boundary.
- Push and pop in the same cycle on a non-full FIFO: level is unchanged.
- `clear_ovf` and a new drop in the same cycle: the drop wins, and `overflow` stays 1.
- `out_data`/`out_bytes` when `out_valid`=0: don't-care for the consumer; hold the last addressed entry.

## Timing
- Reset (async assert, any time including mid-packing):
  - lane=0; b0..b2=0; pointers=0;
  - `level`=0, `out_valid`=0, `overflow`=0, `out_data`=0, `out_bytes`=0;
  - any partial word is discarded.
- Deassertion is synchronised by the system; the first active edge after deassertion may accept `f_valid`.
- Latency: a word completed at edge N (4th byte or flush) drives `out_valid`=1 in the cycle after edge N.
  - This holds when the FIFO was empty.
- With continuous `f_valid` and `out_ready` held high, one word is produced every 4 cycles and the FIFO never exceeds level 1.
- `out_valid`, `level`, and `overflow` are registered; `out_ready` has no combinational path to any output.

## Configuration
- `VP_PACK_DROP_CNT_EN` defined:
  - adds output port `drop_count` [7:0];
  - counts dropped words, saturating at 255;
  - reset value 0; cleared by `clear_ovf`, unless a drop occurs in the same cycle, in which case it becomes 1.
- `VP_PACK_DROP_CNT_EN` undefined:
  - the port and counter are absent;
  - all other behaviour is identical.

## Test plan
- Basic packing: reset, then `out_ready`=1, `f_valid`=1 for 4 cycles with ff,8f,de,1a.
  - Required: one cycle after the 4th edge, `out_valid`=1, `out_data`=1a_de_8f_ff, `out_bytes`=4; `level` returns to 0 after the pop.
- Flush partial: bytes 34,05,72 then `flush` alone.
  - Required: `out_data`=00_72_05_34, `out_bytes`=3.
  - Then `flush` with lane 0 produces no word.
- Flush with byte: lane 3 (25,13,15 packed), then `f_valid`=1 with d2 and `flush`=1.
  - Required: exactly one word, d2_15_13_25, `out_bytes`=4.
- Backpressure/overflow (FIFO_DEPTH=4): `out_ready`=0, then 20 consecutive bytes.
  - Required: `level`=4 after 16 bytes; the 5th word is dropped; `overflow`=1; `drop_count`=1 if configured.
  - Then `out_ready`=1 pops the 4 stored words in order.
  - `clear_ovf` clears the flag.
- Full with simultaneous pop: FIFO full, `out_ready`=1 on the cycle a 4th byte arrives.
  - Required: the word is accepted, `level` stays 4, and `overflow` stays 0.
- Reset mid-operation: assert `reset`=0 asynchronously with lane=2 and level=3.
  - Required: outputs go to reset values immediately.
  - After release, bytes a1,12,7a,49 yield 49_7a_12_a1 with no stale bytes.
